// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS_DEFAULT = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam seg_t HEX_SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_n
);

  assign seg_n = HEX_SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned double buffering.
// The scan-rate input is sampled in the clock_in domain and never used as a clock.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic                    slow_clock,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output seg_t                    seg_n,
  output logic                    dp_n,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int unsigned ValW = 4 * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OneHot0 = NUM_DIGITS'(1);

  logic                  s1_q, s2_q, s3_q;
  logic                  tick, wrap;
  logic [IdxW-1:0]       idx_q, idx_d, next_idx;
  logic [ValW-1:0]       val_pend_q, val_pend_d, val_disp_q, val_disp_d;
  logic [NUM_DIGITS-1:0] dp_pend_q, dp_pend_d, dp_disp_q, dp_disp_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  seg_t                  seg_q, seg_d, dec_seg;
  logic                  dp_q, dp_d;
  logic                  frame_done_q;
  logic [3:0]            sel_nibble;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;

  assign tick     = s2_q & ~s3_q;
  assign wrap     = tick && (idx_q == LastIdx);
  assign next_idx = wrap ? '0 : idx_q + 1'b1;
  assign idx_d    = tick ? next_idx : idx_q;

  always_comb begin
    val_pend_d = val_pend_q;
    dp_pend_d  = dp_pend_q;
    val_disp_d = val_disp_q;
    dp_disp_d  = dp_disp_q;
    pending_d  = pending_q;
    if (wrap) begin
      // A load landing on the wrap tick skips the pending stage entirely
      if (load) begin
        val_disp_d = value_in;
        dp_disp_d  = dp_in;
      end else if (pending_q) begin
        val_disp_d = val_pend_q;
        dp_disp_d  = dp_pend_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      val_pend_d = value_in;
      dp_pend_d  = dp_in;
      pending_d  = 1'b1;
    end
  end

  // lead_zero[k] is set when nibbles k..top are all zero; digit 0 never blanks
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      zero_run     = zero_run & (val_disp_d[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
  end

  assign sel_nibble = val_disp_d[{next_idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (sel_nibble),
    .seg_n  (dec_seg)
  );

  always_comb begin
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    if (tick) begin
      anode_d = ~(OneHot0 << next_idx);
      seg_d   = (BLANK_LZ && lead_zero[next_idx]) ? SEG_BLANK : dec_seg;
      dp_d    = ~dp_disp_d[next_idx];
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      idx_q        <= '0;
      val_pend_q   <= '0;
      dp_pend_q    <= '0;
      val_disp_q   <= '0;
      dp_disp_q    <= '0;
      pending_q    <= 1'b0;
      anode_q      <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      s1_q         <= slow_clock;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      idx_q        <= idx_d;
      val_pend_q   <= val_pend_d;
      dp_pend_q    <= dp_pend_d;
      val_disp_q   <= val_disp_d;
      dp_disp_q    <= dp_disp_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
    end
  end

  assign anode_n    = anode_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a frame-level display model.
module tb_seven_seg_scanner;
  import seven_seg_pkg::*;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clock_in, reset_n, slow_clock, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  anode_n, anode_nb;
  logic [6:0]  seg_n, seg_nb;
  logic        dp_n, dp_nb, pending, pending_nb, frame_done, frame_done_nb;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what the display should show, independent of the RTL's registers
  int          m_digit;
  bit          m_lit, m_pend;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp;

  seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_LZ(1'b1)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clock (slow_clock),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .pending    (pending),
    .frame_done (frame_done)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_LZ(1'b0)) dut_nb (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clock (slow_clock),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .anode_n    (anode_nb),
    .seg_n      (seg_nb),
    .dp_n       (dp_nb),
    .pending    (pending_nb),
    .frame_done (frame_done_nb)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit blank);
    logic [3:0] nib;
    nib = v[4*d +: 4];
    if (blank && d > 0 && (v >> (4 * d)) == 16'h0) return 7'h7F;
    return HEX[nib];
  endfunction

  task automatic model_reset();
    m_digit = 0;
    m_lit   = 1'b0;
    m_pend  = 1'b0;
    m_val   = '0;
    m_pval  = '0;
    m_dp    = '0;
    m_pdp   = '0;
  endtask

  task automatic check_outputs(input string tag, input bit exp_fd);
    logic [3:0] ea;
    logic [6:0] es1, es0;
    logic       edp;
    ea  = ANODE_OFF;
    es1 = SEG_BLANK;
    es0 = SEG_BLANK;
    edp = 1'b1;
    if (m_lit) begin
      ea  = ~(4'b0001 << m_digit);
      es1 = exp_seg(m_val, m_digit, 1'b1);
      es0 = exp_seg(m_val, m_digit, 1'b0);
      edp = ~m_dp[m_digit];
    end
    check_eq({tag, ".anode"},  anode_n, ea);
    check_eq({tag, ".seg"},    seg_n, es1);
    check_eq({tag, ".dp"},     dp_n, edp);
    check_eq({tag, ".pend"},   pending, m_pend);
    check_eq({tag, ".fdone"},  frame_done, exp_fd);
    check_eq({tag, ".anode0"}, anode_nb, ea);
    check_eq({tag, ".seg0"},   seg_nb, es0);
    check_eq({tag, ".dp0"},    dp_nb, edp);
    check_eq({tag, ".pend0"},  pending_nb, m_pend);
    check_eq({tag, ".fdone0"}, frame_done_nb, exp_fd);
  endtask

  // Called just after a rising edge; one load pulse outside any tick cycle
  task automatic mid_load(input logic [15:0] v, input logic [3:0] dp, input string tag);
    value_in = v;
    dp_in    = dp;
    load     = 1'b1;
    @(posedge clock_in); #1;
    load   = 1'b0;
    m_pval = v;
    m_pdp  = dp;
    m_pend = 1'b1;
    @(negedge clock_in);
    check_outputs(tag, 1'b0);
    @(posedge clock_in); #1;
  endtask

  // One slow_clock period; optionally pulses load on the tick cycle itself
  task automatic scan_period(input bit ld, input logic [15:0] v, input logic [3:0] dp,
                             input string tag);
    bit wrap;
    slow_clock = 1'b1;
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    if (ld) begin
      value_in = v;
      dp_in    = dp;
      load     = 1'b1;
    end
    @(negedge clock_in);
    check_outputs({tag, ".pre"}, 1'b0);
    @(posedge clock_in); #1;
    load = 1'b0;
    wrap = (m_digit == 3);
    m_digit = (m_digit + 1) % 4;
    m_lit   = 1'b1;
    if (wrap) begin
      if (ld) begin
        m_val = v;
        m_dp  = dp;
      end else if (m_pend) begin
        m_val = m_pval;
        m_dp  = m_pdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pval = v;
      m_pdp  = dp;
      m_pend = 1'b1;
    end
    @(negedge clock_in);
    check_outputs(tag, wrap);
    repeat ($urandom_range(0, 3)) @(posedge clock_in);
    slow_clock = 1'b0;
    repeat ($urandom_range(3, 6)) @(posedge clock_in);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    slow_clock = 1'b0;
    load       = 1'b0;
    value_in   = '0;
    dp_in      = '0;
    model_reset();
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    check_outputs("in_reset", 1'b0);
    @(posedge clock_in); #1;
    reset_n = 1'b1;
    repeat (50) @(posedge clock_in);
    @(negedge clock_in);
    check_outputs("idle", 1'b0);
    @(posedge clock_in); #1;

    mid_load(16'h12AF, 4'h0, "load_12af");
    for (int i = 0; i < 8; i++) scan_period(1'b0, '0, '0, "scan_12af");

    mid_load(16'h0007, 4'h0, "load_0007");
    for (int i = 0; i < 8; i++) scan_period(1'b0, '0, '0, "scan_0007");

    while (m_digit != 1) scan_period(1'b0, '0, '0, "adv1");
    mid_load(16'h1111, 4'h0, "load_mid");
    for (int i = 0; i < 4; i++) scan_period(1'b0, '0, '0, "scan_1111");

    while (m_digit != 3) scan_period(1'b0, '0, '0, "adv3");
    scan_period(1'b1, 16'hC0DE, 4'h5, "wrap_load");

    for (int i = 0; i < 48; i++) begin
      logic [15:0] rv;
      logic [3:0]  rd;
      rv = 16'($urandom);
      rd = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv >> (4 * $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) mid_load(rv, rd, "rnd_load");
      scan_period($urandom_range(0, 4) == 0, 16'($urandom), 4'($urandom), "rnd_scan");
    end

    while (m_digit != 2) scan_period(1'b0, '0, '0, "adv2");
    mid_load(16'hBEEF, 4'hF, "load_pre_rst");
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst", 1'b0);
    repeat (2) @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock_in);
    #1;
    scan_period(1'b0, '0, '0, "post_rst");
    scan_period(1'b0, '0, '0, "post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed 4-digit, common-anode seven-segment driver for board display output. It sits directly downstream of the slowed-down clock divider and takes that divider's `clock_out` as its scan-rate input. It samples that signal synchronously in the fast `clock_in` domain and never uses it as a clock. Each scan tick advances the lit digit. New display values are double-buffered so that a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: digits scanned; the index counter is 2 bits wide.
- `BLANK_LZ`, 1: when 1, leading zero digits are blanked. Digit 0 is never blanked.
- `clock_in`  input  1: fast board clock; all state is clocked on its rising edge.
- `reset_n`  input  1: asynchronous assert, active-low reset.
- `slow_clock`  input  1: scan-rate square wave from the divider; asynchronous to this block's logic.
- `value_in`  input  16: four hex nibbles; nibble i maps to digit i (digit 0 is least significant).
- `dp_in`  input  4: decimal point request per digit; 1 lights the point.
- `load`  input  1: single-cycle strobe that captures `value_in` and `dp_in`.
- `anode_n`  output  4: digit enables, active-low, one-hot-low.
- `seg_n`  output  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`  output  1: decimal point segment, active-low.
- `pending`  output  1: high while a loaded value waits for the next frame boundary.
- `frame_done`  output  1: one-cycle pulse at each digit 3→0 wrap.

## Operation
- `slow_clock` passes through a 2-flop synchronizer (`s1`, `s2`) and a history flop `s3`.
- `tick = s2 & ~s3`: exactly one `clock_in` cycle per `slow_clock` rising edge. `slow_clock` falling edges are ignored.
- Digit index `idx`:
  - Increments modulo 4 on every tick.
  - Holds otherwise.
- On a tick, the registered outputs update to show `next_idx`:
  - `anode_n` = all ones except bit `next_idx`, which is 0.
  - `seg_n` = hex decode of display nibble `next_idx`.
  - `dp_n` = ~display `dp[next_idx]`.
- Hex decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanking (`BLANK_LZ`=1):
  - Digit k>0 is blanked when all nibbles k..3 are zero.
  - A blanked digit drives `seg_n`=1111111. Its `dp_n` still follows `dp_in`, and its anode is still driven.
- Buffering:
  - `load` copies `value_in`/`dp_in` into the pending register and sets `pending`=1.
  - On a wrap tick (idx 3→0), when `pending`=1, the pending value is copied into the display register and `pending` clears.
  - The digit-0 outputs of that same tick already use the new value.
  - `load` on the wrap-tick cycle bypasses the pending register: `value_in` goes straight to display, and `pending` ends 0.
  - Repeated `load`s before a wrap overwrite the pending value; the last one wins.
- `frame_done` = 1 for the cycle following each wrap tick, whether or not a value was transferred.

## Timing
- Reset values (asynchronous):
  - idx=0, s1=s2=s3=0.
  - `anode_n`=1111 (all off), `seg_n`=1111111, `dp_n`=1.
  - Display and pending registers 0, `pending`=0, `frame_done`=0.
- After reset, all digits stay dark until the first tick. The first tick lights digit 1 (idx 0→1).
- Latency: outputs change on the 3rd `clock_in` rising edge after `slow_clock` goes high (2 synchronizer edges, then the registered update).
- If `slow_clock` is high out of reset, the first tick occurs 2 edges after reset release.
- `slow_clock` high or low phases shorter than 2 `clock_in` periods are outside the contract.
- `load` → `pending`=1 on the next edge. Transfer to display happens at the next wrap tick: worst case 4 ticks.
- Reset asserted mid-frame blanks the outputs immediately and discards any pending value.

## Structure
- Package `seven_seg_pkg`:
  - `NUM_DIGITS_DEFAULT`
  - `SEG_BLANK` = 7'h7F
  - `ANODE_OFF` = 4'hF
  - `typedef logic [6:0] seg_t`
  - Hex-to-segment constant array
- Sub-module `hex_to_seg`: combinational 4-bit → `seg_t` decoder, instantiated once on the selected nibble.
- The tick synchronizer stays inline; it is 3 flops.

## Test plan
- Reset, hold `slow_clock`=0 for 50 cycles → `anode_n`=1111, `seg_n`=1111111, `dp_n`=1, `pending`=0.
- `load` with `value_in`=16'h12AF, `dp_in`=0, then 8 `slow_clock` periods →
  - Sequence digit1 "A"=0001000, digit2 "2"=0100100, digit3 "1"=1111001, then digit0 "F"=0001110 with `frame_done` pulsed.
  - Each change lands exactly 3 edges after a `slow_clock` rise.
- `value_in`=16'h0007, `BLANK_LZ`=1 → digits 3..1 show 1111111 and digit 0 shows 1111000. With `BLANK_LZ`=0, digits 3..1 show 1000000.
- `load` 16'h1111 mid-frame at idx=1 → display unchanged until the 3→0 wrap; `pending`=1 meanwhile; the first digit-0 output after the wrap shows new value 1111001.
- `load` on the exact wrap-tick cycle → the new value is shown at digit 0 in that same update, and `pending` stays 0.
- Assert `reset_n` at idx=2 with `pending`=1 → all outputs off immediately and `pending`=0; after release, the next tick lights digit 1.
